// File: rtl/imu_pkg.sv
// imu_pkg: shared FSM states, register map, bank encodings and reset values
// for the IMU SPI target and its initiator.
// Contents: state_t, ADDR_* register addresses, BANK_* encodings,
// RST_* reset values, SNAP_BYTES, is_writable() map helper.
package imu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE_DATA,
        READ_DATA
    } state_t;

    localparam logic [6:0] ADDR_WHO_AM_I      = 7'h00;
    localparam logic [6:0] ADDR_GYRO_CONFIG_1 = 7'h01;
    localparam logic [6:0] ADDR_PWR_MGMT_1    = 7'h06;
    localparam logic [6:0] ADDR_PWR_MGMT_2    = 7'h07;
    localparam logic [6:0] ADDR_ACCEL_CONFIG  = 7'h14;
    localparam logic [6:0] ADDR_SNAP_FIRST    = 7'h2D;
    localparam logic [6:0] ADDR_SNAP_LAST     = 7'h38;
    localparam logic [6:0] ADDR_REG_BANK_SEL  = 7'h7F;

    localparam logic [1:0] BANK_0 = 2'd0;
    localparam logic [1:0] BANK_2 = 2'd2;

    localparam logic [7:0] RST_PWR_MGMT_1    = 8'h41;
    localparam logic [7:0] RST_PWR_MGMT_2    = 8'h00;
    localparam logic [7:0] RST_GYRO_CONFIG_1 = 8'h01;
    localparam logic [7:0] RST_ACCEL_CONFIG  = 8'h01;

    localparam int SNAP_BYTES = 12;

    // True for addresses that accept writes in the given bank.
    function automatic logic is_writable(input logic [1:0] b, input logic [6:0] a);
        return (a == ADDR_REG_BANK_SEL) ||
               (b == BANK_0 && (a == ADDR_PWR_MGMT_1 || a == ADDR_PWR_MGMT_2)) ||
               (b == BANK_2 && (a == ADDR_GYRO_CONFIG_1 || a == ADDR_ACCEL_CONFIG));
    endfunction

endpackage

// File: rtl/imu_spi_target_if.sv
// imu_spi_target_if: SPI bus between initiator and IMU target.
// Signals: cs (active-low select), sclk (mode 0 clock), sdi (to target), sdo (from target).
// Modports: master = initiator side, slave = target side.
interface imu_spi_target_if;
    logic cs;
    logic sclk;
    logic sdi;
    logic sdo;

    modport master (output cs, sclk, sdi, input sdo);
    modport slave  (input cs, sclk, sdi, output sdo);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rise/fall detect on the synchronized level.
// Ports: hz100 clock, n_rst async active-low reset, d async input,
// q synchronized level, rise/fall one-cycle edge pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic hz100,
    input  logic n_rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, prev;

    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/imu_spi_target.sv
// imu_spi_target: SPI mode-0 register target with banked register map and sensor snapshot.
// Ports: hz100 clock, n_rst async active-low reset, bus (SPI slave modport),
// sensor_data live sensor words, pwr_mgmt_1/pwr_mgmt_2/gyro_config_1/accel_config
// register contents, bank current bank, wr_strobe per committed write,
// xfer_done per transaction end.
module imu_spi_target
    import imu_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hEA
) (
    input  logic            hz100,
    input  logic            n_rst,
    imu_spi_target_if.slave bus,
    input  logic [95:0]     sensor_data,
    output logic [7:0]      pwr_mgmt_1,
    output logic [7:0]      pwr_mgmt_2,
    output logic [7:0]      gyro_config_1,
    output logic [7:0]      accel_config,
    output logic [1:0]      bank,
    output logic            wr_strobe,
    output logic            xfer_done
);

    state_t state, state_nxt;
    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic [1:0] sdi_ff;
    logic sdi_s;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [6:0] addr;
    logic [7:0] shift_out;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic [7:0] snap [SNAP_BYTES];
    logic [3:0] snap_idx;
    logic abort, start, byte_done;

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .hz100(hz100), .n_rst(n_rst), .d(bus.cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .hz100(hz100), .n_rst(n_rst), .d(bus.sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    // sdi shares the two-stage latency of sclk, so sdi_s is aligned with sclk_rise.
    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) sdi_ff <= 2'b00;
        else        sdi_ff <= {sdi_ff[0], bus.sdi};
    end
    assign sdi_s = sdi_ff[1];

    // cs rising outranks any byte completing in the same cycle.
    assign abort     = cs_rise && state != IDLE;
    // Mode 0 idles sclk low; a select arriving with sclk high is not a valid start.
    assign start     = state == IDLE && cs_fall && !sclk_s;
    assign byte_done = sclk_rise && bit_cnt == 3'd7;
    assign rx_byte   = {shift_in, sdi_s};
    assign snap_idx  = 4'(addr - ADDR_SNAP_FIRST);

    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else if (start)
            state_nxt = CMD;
        else if (state == CMD && byte_done)
            state_nxt = rx_byte[7] ? READ_DATA : WRITE_DATA;
    end

    always_comb begin
        rd_byte = 8'h00;
        if (addr == ADDR_REG_BANK_SEL)
            rd_byte = {2'b00, bank, 4'h0};
        else if (bank == BANK_0)
            rd_byte = addr == ADDR_WHO_AM_I   ? WHO_AM_I_VAL :
                      addr == ADDR_PWR_MGMT_1 ? pwr_mgmt_1 :
                      addr == ADDR_PWR_MGMT_2 ? pwr_mgmt_2 :
                      (addr >= ADDR_SNAP_FIRST && addr <= ADDR_SNAP_LAST) ? snap[snap_idx] : 8'h00;
        else if (bank == BANK_2)
            rd_byte = addr == ADDR_GYRO_CONFIG_1 ? gyro_config_1 :
                      addr == ADDR_ACCEL_CONFIG  ? accel_config : 8'h00;
    end

    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt       <= 3'd0;
            shift_in      <= 7'h00;
            shift_out     <= 8'h00;
            addr          <= 7'h00;
            bank          <= BANK_0;
            pwr_mgmt_1    <= RST_PWR_MGMT_1;
            pwr_mgmt_2    <= RST_PWR_MGMT_2;
            gyro_config_1 <= RST_GYRO_CONFIG_1;
            accel_config  <= RST_ACCEL_CONFIG;
            wr_strobe     <= 1'b0;
            xfer_done     <= 1'b0;
            for (int i = 0; i < SNAP_BYTES; i++) snap[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            xfer_done <= abort;
            if (start) begin
                for (int i = 0; i < SNAP_BYTES; i++) snap[i] <= sensor_data[95 - 8*i -: 8];
                bit_cnt   <= 3'd0;
                shift_out <= 8'h00;
            end else if (!abort && state != IDLE) begin
                if (sclk_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    shift_in <= rx_byte[6:0];
                end
                if (state == CMD && byte_done)
                    addr <= rx_byte[6:0];
                if (state == WRITE_DATA && byte_done) begin
                    addr      <= addr + 7'd1;
                    wr_strobe <= is_writable(bank, addr);
                    if (addr == ADDR_REG_BANK_SEL)                   bank          <= rx_byte[5:4];
                    if (bank == BANK_0 && addr == ADDR_PWR_MGMT_1)    pwr_mgmt_1    <= rx_byte;
                    if (bank == BANK_0 && addr == ADDR_PWR_MGMT_2)    pwr_mgmt_2    <= rx_byte;
                    if (bank == BANK_2 && addr == ADDR_GYRO_CONFIG_1) gyro_config_1 <= rx_byte;
                    if (bank == BANK_2 && addr == ADDR_ACCEL_CONFIG)  accel_config  <= rx_byte;
                end
                // bit_cnt==0 on a fall means the previous byte has been fully clocked out.
                if (state == READ_DATA && sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        shift_out <= rd_byte;
                        addr      <= addr + 7'd1;
                    end else begin
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.sdo = (state == READ_DATA && !cs_s) ? shift_out[7] : 1'b0;

endmodule

// File: tb/tb_imu_spi_target.sv
// tb_imu_spi_target: directed + randomized bench for imu_spi_target against a register-array model.
module tb_imu_spi_target;
    import imu_pkg::*;

    localparam int HALF = 6;

    logic        hz100 = 1'b0;
    logic        n_rst = 1'b1;
    logic [95:0] sensor_data = '0;
    logic [7:0]  pwr_mgmt_1, pwr_mgmt_2, gyro_config_1, accel_config;
    logic [1:0]  bank;
    logic        wr_strobe, xfer_done;

    imu_spi_target_if bus();

    imu_spi_target dut (
        .hz100(hz100), .n_rst(n_rst), .bus(bus.slave), .sensor_data(sensor_data),
        .pwr_mgmt_1(pwr_mgmt_1), .pwr_mgmt_2(pwr_mgmt_2), .gyro_config_1(gyro_config_1),
        .accel_config(accel_config), .bank(bank), .wr_strobe(wr_strobe), .xfer_done(xfer_done)
    );

    always #5 hz100 = ~hz100;

    int n_cmp = 0, n_err = 0, n_wr = 0, n_xd = 0, exp_wr = 0, change_at = -1;

    always @(negedge hz100) begin
        if (wr_strobe) n_wr <= n_wr + 1;
        if (xfer_done) n_xd <= n_xd + 1;
    end

    // Model: one byte per (bank, address), a writable map, and the bank register.
    logic [7:0] mreg [4][128];
    bit         mw   [4][128];
    logic [1:0] mbank;
    logic [7:0] wq [$];

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 128; a++) begin
                mreg[b][a] = 8'h00;
                mw[b][a]   = 1'b0;
            end
        mbank = 2'd0;
        mreg[0][0]  = 8'hEA;
        mreg[0][6]  = 8'h41; mw[0][6]  = 1'b1;
        mreg[0][7]  = 8'h00; mw[0][7]  = 1'b1;
        mreg[2][1]  = 8'h01; mw[2][1]  = 1'b1;
        mreg[2][20] = 8'h01; mw[2][20] = 1'b1;
    endtask

    task automatic model_snap();
        for (int i = 0; i < 12; i++) mreg[0][45 + i] = sensor_data[95 - 8*i -: 8];
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        return (a == 7'h7F) ? {2'b00, mbank, 4'h0} : mreg[mbank][a];
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        if (a == 7'h7F) begin
            mbank = d[5:4];
            exp_wr++;
        end else if (mw[mbank][a]) begin
            mreg[mbank][a] = d;
            exp_wr++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge hz100);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pwr1"}, pwr_mgmt_1, mreg[0][6]);
        chk({tag, ".pwr2"}, pwr_mgmt_2, mreg[0][7]);
        chk({tag, ".gyro"}, gyro_config_1, mreg[2][1]);
        chk({tag, ".accel"}, accel_config, mreg[2][20]);
        chk({tag, ".bank"}, bank, mbank);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        bus.sdi = b;
        wait_cyc(HALF);
        bus.sclk = 1'b1;
        r = bus.sdo;
        wait_cyc(HALF);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic cs_low();
        model_snap();
        bus.cs = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        bus.cs = 1'b1;
        wait_cyc(10);
    endtask

    task automatic write_burst(input logic [6:0] a, input int n);
        int w0, x0;
        logic [7:0] r;
        logic [6:0] aa;
        w0 = n_wr; x0 = n_xd; exp_wr = 0; aa = a;
        cs_low();
        spi_byte({1'b0, a}, r);
        for (int i = 0; i < n; i++) begin
            spi_byte(wq[i], r);
            model_write(aa, wq[i]);
            aa++;
        end
        cs_high();
        chk($sformatf("wr%02h.strobes", a), n_wr - w0, exp_wr);
        chk($sformatf("wr%02h.xfer", a), n_xd - x0, 1);
        check_regs($sformatf("wr%02h", a));
    endtask

    task automatic read_burst(input logic [6:0] a, input int n);
        int w0, x0;
        logic [7:0] r;
        logic [6:0] aa;
        w0 = n_wr; x0 = n_xd; aa = a;
        cs_low();
        spi_byte({1'b1, a}, r);
        for (int i = 0; i < n; i++) begin
            if (i == change_at) sensor_data = {$urandom, $urandom, $urandom};
            spi_byte(8'h00, r);
            chk($sformatf("rd%02h", aa), r, model_read(aa));
            aa++;
        end
        cs_high();
        chk($sformatf("rd%02h.strobes", a), n_wr - w0, 0);
        chk($sformatf("rd%02h.xfer", a), n_xd - x0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [6:0] picks [10];
        int w0, x0;
        bus.cs = 1'b1; bus.sclk = 1'b0; bus.sdi = 1'b0;
        model_reset();
        #1 n_rst = 1'b0;
        wait_cyc(4);
        check_regs("reset");
        chk("reset.sdo", bus.sdo, 0);
        chk("reset.wr_strobe", wr_strobe, 0);
        chk("reset.xfer_done", xfer_done, 0);
        n_rst = 1'b1;
        wait_cyc(4);

        wq = '{8'h01};
        write_burst(7'h06, 1);
        chk("pwr1_write", pwr_mgmt_1, 8'h01);

        wq = '{8'h20};
        write_burst(7'h7F, 1);
        wq = '{8'h33};
        write_burst(7'h14, 1);
        chk("bank2", bank, 2'd2);
        chk("accel_33", accel_config, 8'h33);
        read_burst(7'h14, 1);

        wq = '{8'h00};
        write_burst(7'h7F, 1);
        read_burst(7'h00, 2);

        sensor_data = 96'h0102_0304_0506_0708_090A_0B0C;
        change_at = 4;
        read_burst(7'h2D, 10);
        sensor_data = {$urandom, $urandom, $urandom};
        read_burst(7'h2D, 16);
        change_at = -1;

        // Partial data byte then deselect: nothing commits.
        w0 = n_wr; x0 = n_xd;
        cs_low();
        spi_byte(8'h06, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r[0]);
        cs_high();
        chk("partial.strobes", n_wr - w0, 0);
        chk("partial.xfer", n_xd - x0, 1);
        check_regs("partial");

        // Eighth data bit and deselect land together: deselect wins.
        w0 = n_wr; x0 = n_xd;
        cs_low();
        spi_byte(8'h06, r);
        for (int i = 0; i < 7; i++) spi_bit(1'b0, r[0]);
        bus.sdi = 1'b1;
        wait_cyc(HALF);
        bus.sclk = 1'b1;
        bus.cs = 1'b1;
        wait_cyc(HALF);
        bus.sclk = 1'b0;
        wait_cyc(10);
        chk("coincide.strobes", n_wr - w0, 0);
        chk("coincide.xfer", n_xd - x0, 1);
        check_regs("coincide");

        // Address wrap 0x7E -> 0x7F -> 0x00.
        wq = '{8'h5A, 8'h00, 8'h77};
        write_burst(7'h7E, 3);
        read_burst(7'h7E, 4);

        // Reset in the middle of a burst read.
        wq = '{8'h9C};
        write_burst(7'h07, 1);
        cs_low();
        spi_byte(8'h86, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r[0]);
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("rstmid.sdo", bus.sdo, 0);
        chk("rstmid.wr_strobe", wr_strobe, 0);
        chk("rstmid.xfer_done", xfer_done, 0);
        check_regs("rstmid");
        bus.cs = 1'b1; bus.sclk = 1'b0;
        wait_cyc(4);
        n_rst = 1'b1;
        wait_cyc(6);
        wq = '{8'h09};
        write_burst(7'h06, 1);
        read_burst(7'h06, 2);

        picks = '{7'h00, 7'h01, 7'h06, 7'h07, 7'h14, 7'h2D, 7'h38, 7'h7F, 7'h7E, 7'h00};
        for (int t = 0; t < 30; t++) begin
            int k;
            logic [6:0] a;
            picks[9] = 7'($urandom);
            sensor_data = {$urandom, $urandom, $urandom};
            k = $urandom_range(0, 2);
            a = picks[$urandom_range(0, 9)];
            if (k == 0) begin
                int n;
                n = $urandom_range(1, 3);
                wq.delete();
                for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
                write_burst(a, n);
            end else if (k == 1) begin
                read_burst(a, $urandom_range(1, 4));
            end else begin
                read_burst(7'(45 + $urandom_range(0, 11)), $urandom_range(1, 14));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imu_spi_target.md
IMU_SPI_TARGET -- requirements
Module: imu_spi_target

Interface
REQ-001 Parameter WHO_AM_I_VAL, 8'hEA, value returned by bank-0 register 0x00.
REQ-002 hz100  input  1  system clock; all state on posedge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 cs  input  1  SPI chip select from initiator, active low, asynchronous to hz100.
REQ-005 sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to hz100.
REQ-006 sdi  input  1  initiator-to-target serial data, MSB first.
REQ-007 sdo  output  1  target-to-initiator serial data, MSB first.
REQ-008 sensor_data  input  96  accel X/Y/Z then gyro X/Y/Z, 16 bits each, big-endian, bits [95:88] = register 0x2D.
REQ-009 pwr_mgmt_1, pwr_mgmt_2, gyro_config_1, accel_config  output  8 each  current register contents.
REQ-010 bank  output  2  current bank, REG_BANK_SEL[5:4].
REQ-011 wr_strobe  output  1  one-cycle pulse per committed register write.
REQ-012 xfer_done  output  1  one-cycle pulse on each cs deassertion that ends a transaction.

Function
REQ-013 cs, sclk and sdi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk; sclk high/low phases SHALL each last at least 4 hz100 cycles.
REQ-014 FSM states: IDLE, CMD, WRITE_DATA, READ_DATA.
REQ-015 IDLE -> CMD on synchronized cs falling; on this edge sensor_data SHALL be snapshotted; bit counter cleared.
REQ-016 sdi SHALL be sampled on each synchronized sclk rising edge and shifted into an 8-bit register MSB first.
REQ-017 After 8 bits in CMD: bit7=1 -> READ_DATA, bit7=0 -> WRITE_DATA; address = bits[6:0].
REQ-018 READ_DATA: the addressed byte SHALL be loaded into the shift-out register on the synchronized sclk falling edge following the 8th command bit; sdo SHALL update on each subsequent falling edge.
REQ-019 WRITE_DATA: on every 8th data bit the received byte SHALL commit to the addressed register and pulse wr_strobe the same cycle.
REQ-020 Address SHALL auto-increment after each data byte in both directions, wrapping 0x7F -> 0x00, bank unchanged.
REQ-021 Register map: any bank 0x7F REG_BANK_SEL (R/W); bank 0: 0x00 WHO_AM_I (RO), 0x06 PWR_MGMT_1 (R/W), 0x07 PWR_MGMT_2 (R/W), 0x2D-0x38 sensor snapshot (RO); bank 2: 0x01 GYRO_CONFIG_1 (R/W), 0x14 ACCEL_CONFIG (R/W).
REQ-022 Unmapped reads SHALL return 8'h00; writes to RO or unmapped addresses SHALL be ignored with no wr_strobe.
REQ-023 Burst reads SHALL return snapshot bytes, never live sensor_data, for the whole transaction.
REQ-024 sdo SHALL be 0 whenever the synchronized cs is high or state is not READ_DATA.
REQ-025 Synchronized cs rising in any non-IDLE state SHALL return to IDLE, discard a partial byte, and pulse xfer_done.
REQ-026 A byte completion and cs rising in the same cycle: cs rising wins; the byte SHALL be discarded.
REQ-027 More than 13 data bytes SHALL continue via auto-increment with no error.

Reset
REQ-028 On n_rst low: state IDLE, sdo 0, wr_strobe 0, xfer_done 0, bank 0, pwr_mgmt_1 8'h41, pwr_mgmt_2 8'h00, gyro_config_1 8'h01, accel_config 8'h01, snapshot 0, synchronizers to cs=1/sclk=0/sdi=0.
REQ-029 Reset mid-transaction SHALL abort without committing; operation resumes on the next cs falling edge after release.

Structure
REQ-030 Package imu_pkg SHALL hold the state enum, register address constants, bank encodings, and reset values, shared with the initiator.
REQ-031 One sub-module, spi_sync_edge, SHALL provide the 2-flop synchronizer plus rise/fall detect, instantiated for cs and sclk.

Verification
REQ-032 Write 0x06,0x01 in bank 0 -> pwr_mgmt_1=8'h01, one wr_strobe, one xfer_done.
REQ-033 Write 0x7F,0x20 then 0x14,0x33 -> bank=2, accel_config=8'h33; read 0x94 -> sdo 0x33.
REQ-034 Bank 0 read 0x80 with 16 clocks -> sdo bytes 0xEA, 0x00 (0x01 unmapped in bank 0).
REQ-035 sensor_data=96'h0102_0304_0506_0708_090A_0B0C, read 0xAD for 80 data bits; change sensor_data mid-burst -> sdo returns 0x01..0x0A unchanged.
REQ-036 Write 0x06 then cs high after 4 data bits -> pwr_mgmt_1 stays 8'h41, no wr_strobe, xfer_done pulses.
REQ-037 Assert n_rst during a burst read -> sdo 0 immediately, all registers at reset values; next transaction works.
